cla_share_sequencer: RTL

CLA_SHARE_SEQUENCER -- requirements
Module: cla_share_sequencer

---
 rtl/cla_seq_pkg.sv | 17 +
 rtl/cla_slice.sv | 62 ++++++
 rtl/cla_share_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the time-shared carry-lookahead adder sequencer.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SLICE_W = 16;

  function automatic int nslice(input int width, input int slice_w);
    return width / slice_w;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE_W-bit adder: 4-bit lookahead blocks joined by a second lookahead level.
module cla_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int NBLK = SLICE_W / 4;

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] c;
  logic [NBLK-1:0]    gg;
  logic [NBLK-1:0]    pg;
  logic [NBLK:0]      cb;
  logic               term;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg   = '0;
    pg   = '0;
    cb   = '0;
    c    = '0;
    term = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Block carries expanded as flat sum-of-products rather than rippled.
    cb[0] = cin;
    for (int k = 0; k < NBLK; k++) begin
      for (int j = 0; j <= k; j++) begin
        term = gg[j];
        for (int m = j + 1; m <= k; m++) term = term & pg[m];
        cb[k+1] = cb[k+1] | term;
      end
      term = cin;
      for (int m = 0; m <= k; m++) term = term & pg[m];
      cb[k+1] = cb[k+1] | term;
    end
    for (int k = 0; k < NBLK; k++) begin
      c[4*k]   = cb[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cb[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cb[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cb[NBLK];

endmodule

// File: rtl/cla_share_sequencer.sv
// Two-requester WIDTH-bit adder that time-shares one cla_slice over NSLICE passes, LSB slice first.
// Optional resp_ovf signed-overflow output is enabled by defining CLA_SEQ_OVF_EN.
module cla_share_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
`ifdef CLA_SEQ_OVF_EN
  output logic             resp_ovf,
`endif
  output logic             resp_cout
);

  localparam int NSLICE = nslice(WIDTH, SLICE_W);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state, state_nxt;
  logic               last_id;
  logic               gnt0, gnt1, accept, last_pass;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_p0, b_p0;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  // Round-robin: on a tie the requester not served last wins.
  assign gnt0      = req0_valid & (~req1_valid | last_id);
  assign gnt1      = req1_valid & ~gnt0;
  assign accept    = (state == IDLE) & (gnt0 | gnt1);
  assign last_pass = (idx == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PASS;
      PASS:    if (last_pass) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE:    begin req0_ready = gnt0; req1_ready = gnt1; end
      DONE:    resp_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef CLA_SEQ_OVF_EN
  function automatic logic ovf_of(input logic a_msb, input logic b_msb,
                                  input logic s_msb, input logic c_out);
    return (a_msb ^ b_msb ^ s_msb) ^ c_out;
  endfunction
`endif

  always_comb begin
    slice_a = a_p0[int'(idx)*SLICE_W +: SLICE_W];
    slice_b = b_p0[int'(idx)*SLICE_W +: SLICE_W];
  end

  cla_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Operand capture: snapshot at accept so later requester changes cannot leak in.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= gnt0 ? req0_a : req1_a;
      b_p0 <= gnt0 ? req0_b : req1_b;
    end
  end

  // Pass stage: one slice per cycle into the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id   <= 1'b1;
      idx       <= '0;
      carry     <= 1'b0;
      resp_id   <= 1'b0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      resp_ovf  <= 1'b0;
`endif
    end else if (accept) begin
      last_id <= gnt1;
      resp_id <= gnt1;
      idx     <= '0;
      carry   <= gnt0 ? req0_cin : req1_cin;
    end else if (state == PASS) begin
      resp_sum[int'(idx)*SLICE_W +: SLICE_W] <= slice_sum;
      carry <= slice_cout;
      idx   <= idx + IDX_W'(1);
      if (last_pass) begin
        resp_cout <= slice_cout;
`ifdef CLA_SEQ_OVF_EN
        resp_ovf  <= ovf_of(slice_a[SLICE_W-1], slice_b[SLICE_W-1],
                            slice_sum[SLICE_W-1], slice_cout);
`endif
      end
    end
  end

endmodule
